// File: rtl/conv_1st_ofm_arb.sv
// First-layer OFM writeback: result FIFO plus WR/RD arbiter on one single-port SRAM.
// Writes go out the cycle after the strobe when uncontested; results are never stalled, and overflow is flagged.

module conv_1st_ofm_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The caller only pushes when space exists and only pops when non-empty.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

endmodule

module conv_1st_ofm_arb #(
  parameter int DATA_W     = 16,
  parameter int AW         = 11,
  parameter int FRAME_LEN  = 2048,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          res_valid,
  input  logic [DATA_W-1:0]             res_data,
  input  logic                          clr,
  input  logic                          rd_req,
  input  logic [AW-1:0]                 rd_addr,
  output logic                          rd_gnt,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frame_done,
  output logic                          ovf
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] URGENT_C  = CW'(FIFO_DEPTH - 1);

  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} gnt_e;

  gnt_e              last_gnt_q, last_gnt_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q, ovf_d;

  logic [CW-1:0]     cnt_w;
  logic [DATA_W-1:0] head_w;
  logic              wr_cand;
  logic              rd_cand;
  logic              wr_win;
  logic              rd_win;
  logic              full;
  logic              push;

  conv_1st_ofm_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (wr_win),
    .din   (res_data),
    .head  (head_w),
    .cnt   (cnt_w)
  );

  // A nearly full FIFO overrides round robin, so occupancy normally stays below
  // FIFO_DEPTH; ovf remains as a sticky safety net.
  always_comb begin
    wr_cand = (cnt_w != '0) && !clr;
    rd_cand = rd_req;
    wr_win  = wr_cand && (!rd_cand || (cnt_w >= URGENT_C) || (last_gnt_q == GNT_RD));
    rd_win  = rd_cand && !wr_win;
    full    = (cnt_w >= DEPTH_C);
    push    = res_valid && !clr && (!full || wr_win);
  end

  always_comb begin
    last_gnt_d   = last_gnt_q;
    wr_addr_d    = wr_addr_q;
    ovf_d        = ovf_q;
    rd_valid_d   = rd_win;
    frame_done_d = wr_win && (wr_addr_q == LAST_ADDR);
    if (wr_win) begin
      last_gnt_d = GNT_WR;
    end else if (rd_win) begin
      last_gnt_d = GNT_RD;
    end
    if (clr) begin
      wr_addr_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (wr_win) begin
        wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + AW'(1);
      end
      if (res_valid && full && !wr_win) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= GNT_WR;
      wr_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign mem_en     = wr_win || rd_win;
  assign mem_we     = wr_win;
  assign mem_addr   = wr_win ? wr_addr_q : rd_addr;
  assign mem_wdata  = head_w;
  assign rd_gnt     = rd_win;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = mem_rdata;
  assign fifo_cnt   = cnt_w;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_conv_1st_ofm_arb.sv
// Bench for conv_1st_ofm_arb: SRAM model, write/read scoreboards and per-scenario tasks.
module tb_conv_1st_ofm_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [10:0] rd_addr = '0;
  logic        rd_gnt, rd_valid, mem_en, mem_we, frame_done, ovf;
  logic [15:0] rd_data, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [10:0] mem_addr;
  logic [2:0]  fifo_cnt;

  typedef struct packed { logic [10:0] a; logic [15:0] d; } wr_t;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  wr_t         mon_e;
  logic [15:0] mon_r;
  logic [10:0] exp_wa = '0;
  int          tests = 0;
  int          fails = 0;

  logic [15:0] tb_mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_a = '0;
  logic [15:0] pre_d = '0;

  conv_1st_ofm_arb #(.DATA_W(16), .AW(11), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data), .clr(clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_cnt(fifo_cnt),
    .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_a] <= pre_d;
    else if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
  end

  // Scoreboard side: every memory write and every returned read is checked in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en && mem_we) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected addr=%0d data=%h", mem_addr, mem_wdata);
        end else begin
          mon_e = wr_q.pop_front();
          if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
            fails++;
            $display("FAIL wr_data got addr=%0d data=%h exp addr=%0d data=%h",
                     mem_addr, mem_wdata, mon_e.a, mon_e.d);
          end
        end
      end
      if (rd_valid) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected data=%h", rd_data);
        end else begin
          mon_r = rd_q.pop_front();
          if (rd_data !== mon_r) begin
            fails++;
            $display("FAIL rd_data got=%h exp=%h", rd_data, mon_r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d);
    wr_q.push_back(wr_t'{a: exp_wa, d: d});
    exp_wa = (exp_wa == 11'd3) ? 11'd0 : exp_wa + 11'd1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_wa = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL reset_fifo_cnt got=%0d exp=0", fifo_cnt); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    tests++; if (rd_gnt !== 1'b0) begin fails++; $display("FAIL reset_rd_gnt got=%b exp=0", rd_gnt); end
    tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    tick();
    rst_n = 1'b1;
    exp_wa = '0;
  endtask

  task automatic test_spaced_writes();
    for (int i = 1; i <= 3; i++) begin
      res_valid = 1'b1;
      res_data = 16'(i);
      push_exp(16'(i));
      @(negedge clk);
      tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL t1_idle got mem_en=%b exp=0", mem_en); end
      tick();
      res_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || fifo_cnt !== 3'd1) begin
        fails++;
        $display("FAIL t1_write_lat got en=%b we=%b cnt=%0d exp en=1 we=1 cnt=1", mem_en, mem_we, fifo_cnt);
      end
      repeat (8) tick();
    end
    @(negedge clk);
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL t1_drain got cnt=%0d exp=0", fifo_cnt); end
    tick();
  endtask

  task automatic test_readback();
    pre_en = 1'b1; pre_a = 11'd5; pre_d = 16'hABCD;
    tick();
    pre_en = 1'b0;
    rd_req = 1'b1; rd_addr = 11'd5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (rd_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd5) begin
        fails++;
        $display("FAIL t2_grant cyc=%0d got gnt=%b en=%b we=%b addr=%0d exp 1 1 0 5", c, rd_gnt, mem_en, mem_we, mem_addr);
      end
      if (c > 0) begin
        tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL t2_b2b_valid cyc=%0d got=%b exp=1", c, rd_valid); end
      end
      rd_q.push_back(16'hABCD);
      tick();
    end
    rd_req = 1'b0;
    @(negedge clk);
    tests++; if (rd_valid !== 1'b1 || rd_gnt !== 1'b0) begin fails++; $display("FAIL t2_tail got valid=%b gnt=%b exp 1 0", rd_valid, rd_gnt); end
    tick();
    @(negedge clk);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL t2_idle got valid=%b exp=0", rd_valid); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rd;
    exp_rd = 5'b10101;
    do_clr();
    res_valid = 1'b1; res_data = 16'h0020; push_exp(16'h0020);
    tick();
    res_valid = 1'b0;
    tick();
    res_valid = 1'b1; res_data = 16'h0021; push_exp(16'h0021);
    tick();
    res_valid = 1'b1; res_data = 16'h0022; push_exp(16'h0022);
    rd_req = 1'b1; rd_addr = 11'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (rd_gnt !== exp_rd[c] || (mem_en & mem_we) !== ~exp_rd[c]) begin
        fails++;
        $display("FAIL t3_alternate cyc=%0d got rd_gnt=%b wr=%b exp rd_gnt=%b", c, rd_gnt, mem_en & mem_we, exp_rd[c]);
      end
      if (exp_rd[c]) rd_q.push_back(16'h0020);
      tick();
      res_valid = 1'b0;
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_urgent();
    logic [2:0]  exp_cnt [13] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    logic [12:0] exp_wr;
    exp_wr = 13'b0_1010_1110_1010;
    do_clr();
    rd_req = 1'b1; rd_addr = 11'd5;
    for (int c = 0; c < 13; c++) begin
      if (c < 7) begin
        res_valid = 1'b1; res_data = 16'(16'h0040 + c); push_exp(16'(16'h0040 + c));
      end else begin
        res_valid = 1'b0;
      end
      @(negedge clk);
      tests++; if (fifo_cnt !== exp_cnt[c]) begin fails++; $display("FAIL t4_cnt cyc=%0d got=%0d exp=%0d", c, fifo_cnt, exp_cnt[c]); end
      tests++;
      if ((mem_en & mem_we) !== exp_wr[c] || rd_gnt !== ~exp_wr[c]) begin
        fails++;
        $display("FAIL t4_grant cyc=%0d got wr=%b rd=%b exp wr=%b", c, mem_en & mem_we, rd_gnt, exp_wr[c]);
      end
      tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL t4_ovf cyc=%0d got=%b exp=0", c, ovf); end
      if (!exp_wr[c]) rd_q.push_back(16'hABCD);
      tick();
    end
    res_valid = 1'b0; rd_req = 1'b0;
    tick();
  endtask

  task automatic test_stress_no_ovf();
    do_clr();
    rd_req = 1'b1; rd_addr = 11'd5;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        res_valid = 1'b1; res_data = 16'(16'h0500 + c); push_exp(16'(16'h0500 + c));
      end else begin
        res_valid = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (fifo_cnt > 3'd3 || ovf !== 1'b0 || mem_en !== 1'b1) begin
        fails++;
        $display("FAIL t5_pressure cyc=%0d got cnt=%0d ovf=%b en=%b exp cnt<=3 ovf=0 en=1", c, fifo_cnt, ovf, mem_en);
      end
      if (rd_gnt) rd_q.push_back(16'hABCD);
      tick();
    end
    rd_req = 1'b0;
    @(negedge clk);
    tests++; if (fifo_cnt !== 3'd0 || wr_q.size() != 0) begin fails++; $display("FAIL t5_drain got cnt=%0d pending=%0d exp 0 0", fifo_cnt, wr_q.size()); end
    tick();
  endtask

  task automatic test_frame_and_clr();
    logic [7:0] exp_fd;
    exp_fd = 8'b0010_0000;
    do_clr();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        res_valid = 1'b1; res_data = 16'(16'h0060 + c); push_exp(16'(16'h0060 + c));
      end else begin
        res_valid = 1'b0;
      end
      @(negedge clk);
      tests++; if (frame_done !== exp_fd[c]) begin fails++; $display("FAIL t6_frame_done cyc=%0d got=%b exp=%b", c, frame_done, exp_fd[c]); end
      tick();
    end
    res_valid = 1'b1; res_data = 16'h0061; push_exp(16'h0061);
    tick();
    res_valid = 1'b0;
    tick();
    res_valid = 1'b1; res_data = 16'h0062;
    tick();
    clr = 1'b1; res_valid = 1'b1; res_data = 16'hDEAD; rd_req = 1'b1; rd_addr = 11'd5;
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b0 || rd_gnt !== 1'b1 || mem_en !== 1'b1) begin
      fails++;
      $display("FAIL t6_clr_arb got we=%b gnt=%b en=%b exp 0 1 1", mem_we, rd_gnt, mem_en);
    end
    rd_q.push_back(16'hABCD);
    tick();
    clr = 1'b0; res_valid = 1'b0; rd_req = 1'b0; exp_wa = '0;
    @(negedge clk);
    tests++;
    if (fifo_cnt !== 3'd0 || rd_valid !== 1'b1 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL t6_after_clr got cnt=%0d valid=%b en=%b exp 0 1 0", fifo_cnt, rd_valid, mem_en);
    end
    res_valid = 1'b1; res_data = 16'h0063; push_exp(16'h0063);
    tick();
    res_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    res_valid = 1'b1; res_data = 16'h0071;
    tick();
    res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (fifo_cnt !== 3'd0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got cnt=%0d en=%b exp 0 0", fifo_cnt, mem_en);
    end
    tick();
    rst_n = 1'b1; exp_wa = '0;
    res_valid = 1'b1; res_data = 16'h0072; push_exp(16'h0072);
    tick();
    res_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_spaced_writes();
    test_readback();
    test_round_robin();
    test_urgent();
    test_stress_no_ovf();
    test_frame_and_clr();
    test_reset_mid();
    repeat (5) tick();
    tests++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL final_drain got wr_pending=%0d rd_pending=%0d exp 0 0", wr_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
